layernorm_row_scheduler: RTL

- Sequences a block of matrix rows through the 20-stage LayerNorm pipeline (16 x Q5.10 per row).
- Issues one row read per cycle from the row buffer and drives the pipeline's valid_in aligned with the read data.
- Counts the pipeline's valid_out pulses and generates the result write addresses.
- Reports done or error to the layer-level sequencer; sits between the row SRAMs and the pipeline.

---
 rtl/layernorm_row_scheduler_pkg.sv | 29 ++
 rtl/ln_valid_delay.sv | 27 ++
 rtl/layernorm_row_scheduler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/layernorm_row_scheduler_pkg.sv
// Shared definitions for the LayerNorm row scheduler and the LayerNorm pipeline top.
package layernorm_row_scheduler_pkg;

  // Scheduler state encoding
  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_ISSUE = 2'd1;
  localparam logic [1:0] STATE_DRAIN = 2'd2;
  localparam logic [1:0] STATE_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_ISSUE = STATE_ISSUE,
    ST_DRAIN = STATE_DRAIN,
    ST_DONE  = STATE_DONE
  } sched_state_t;

  // Pipeline geometry: 20 stages deep, 16 Q5.10 elements per row
  localparam int LN_PIPE_LAT = 20;
  localparam int LN_VEC_LEN  = 16;

  // Extra cycles allowed in DRAIN beyond the worst-case round trip
  localparam int LN_DRAIN_MARGIN = 4;

  // Drain timeout threshold for a given pipeline and read latency
  function automatic int drain_limit(input int pipe_lat, input int rd_lat);
    return pipe_lat + rd_lat + LN_DRAIN_MARGIN;
  endfunction

endpackage

// File: rtl/ln_valid_delay.sv
// RD_LAT-deep valid shift register: lines the pipeline valid_in up with row-buffer read data.
module ln_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  output logic valid_out
);

  logic [DEPTH-1:0] stages;

  // Shift the read strobe one stage per cycle; reset clears every stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages[0] <= valid_in;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign valid_out = stages[DEPTH-1];

endmodule

// File: rtl/layernorm_row_scheduler.sv
// Row scheduler for the LayerNorm pipeline: issues row reads, tracks in-flight rows,
// generates result write addresses and reports done/aborted/err.
// Optional macro LN_SCHED_PERF_EN adds the perf_cycles busy-cycle counter output.
module layernorm_row_scheduler
  import layernorm_row_scheduler_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int ROW_W    = 8,
  parameter int PIPE_LAT = LN_PIPE_LAT,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              ln_valid_in,
  input  logic              ln_valid_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
`ifdef LN_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int FLIGHT_W    = $clog2(PIPE_LAT + RD_LAT + 1) + 1;
  localparam int DRAIN_LIMIT = drain_limit(PIPE_LAT, RD_LAT);
  localparam int DRAIN_W     = $clog2(DRAIN_LIMIT + 1);

  sched_state_t state, state_next;

  logic [ROW_W-1:0]    num_rows_q;
  logic [ROW_W-1:0]    issued;
  logic [ADDR_W-1:0]   rd_base_q;
  logic [ADDR_W-1:0]   wr_base_q;
  logic [ADDR_W-1:0]   written;
  logic [FLIGHT_W-1:0] in_flight;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic                err_q;
  logic                aborted_q;

  logic start_acc;
  logic issue_now;
  logic set_abort;
  logic set_timeout;
  logic accept;
  logic spurious;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_next  = state;
    start_acc   = 1'b0;
    issue_now   = 1'b0;
    set_abort   = 1'b0;
    set_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc  = 1'b1;
          state_next = (num_rows == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          set_abort  = 1'b1;
          state_next = ST_DRAIN;
        end else begin
          issue_now = 1'b1;
          if (issued == num_rows_q - ROW_W'(1)) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (in_flight == '0) begin
          state_next = ST_DONE;
        end else if (drain_cnt == DRAIN_W'(DRAIN_LIMIT)) begin
          set_timeout = 1'b1;
          state_next  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // A returning row is genuine only while rows are outstanding and a run is live
  assign accept   = ln_valid_out && (in_flight != '0) && (state != ST_IDLE);
  assign spurious = ln_valid_out && !accept;

  assign busy    = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done    = (state == ST_DONE);
  assign aborted = aborted_q;
  assign err     = err_q;
  assign rd_en   = issue_now;
  assign rd_addr = rd_base_q + ADDR_W'(issued);
  assign wr_en   = accept && busy;
  assign wr_addr = wr_base_q + written;

  // Latch the run configuration when a start is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_rows_q <= '0;
      rd_base_q  <= '0;
      wr_base_q  <= '0;
    end else if (start_acc) begin
      num_rows_q <= num_rows;
      rd_base_q  <= rd_base;
      wr_base_q  <= wr_base;
    end
  end

  // Issue and write counters; both restart at zero on every accepted start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued  <= '0;
      written <= '0;
    end else if (start_acc) begin
      issued  <= '0;
      written <= '0;
    end else begin
      if (issue_now) begin
        issued <= issued + ROW_W'(1);
      end
      if (wr_en) begin
        written <= written + ADDR_W'(1);
      end
    end
  end

  // In-flight count; a start also discards rows lost by a timed-out previous run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_flight <= '0;
    end else if (start_acc) begin
      in_flight <= '0;
    end else begin
      case ({issue_now, accept})
        2'b10:   in_flight <= in_flight + FLIGHT_W'(1);
        2'b01:   in_flight <= in_flight - FLIGHT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Drain watchdog: counts cycles spent in DRAIN, zero elsewhere
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (state == ST_DRAIN) begin
      drain_cnt <= drain_cnt + DRAIN_W'(1);
    end else begin
      drain_cnt <= '0;
    end
  end

  // Status flags: cleared by an accepted start, then sticky for the rest of the run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      err_q     <= (err_q && !start_acc) || spurious || set_timeout;
      aborted_q <= (aborted_q && !start_acc) || set_abort;
    end
  end

  ln_valid_delay #(
    .DEPTH(RD_LAT)
  ) u_valid_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (issue_now),
    .valid_out(ln_valid_in)
  );

`ifdef LN_SCHED_PERF_EN
  // Busy-cycle counter: restarts on accepted start, saturates, holds once the run ends
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles <= '0;
    end else if (start_acc) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule
